pc_sequencer: RTL and testbench

Multi-cycle program-counter controller for the RV32I core. Owns the PC register, fetches instructions over a request/acknowledge handshake, holds each instruction while the datapath executes it, then resolves the next PC for sequential flow, conditional branches (all `b_func` encodings), JAL and JALR. Sits between instruction memory and the datapath; replaces the combinational next-PC path of the single-cycle core.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/branch_cmp.sv | 24 ++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: branch function codes, control-flow opcodes and
// the state encoding of the multi-cycle PC sequencer.
package riscv_pkg;

    typedef enum logic [2:0] {
        B_EQ  = 3'b000,
        B_NE  = 3'b001,
        B_LT  = 3'b100,
        B_GE  = 3'b101,
        B_LTU = 3'b110,
        B_GEU = 3'b111
    } b_func_e;

    typedef enum logic [6:0] {
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } pcs_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator for all RV32I b_func encodings.
module branch_cmp
    import riscv_pkg::*;
(
    input  logic [2:0]  b_func,
    input  logic [31:0] rv1,
    input  logic [31:0] rv2,
    output logic        take
);

    always_comb begin
        take = 1'b0;
        case (b_func)
            B_EQ:    take = (rv1 == rv2);
            B_NE:    take = (rv1 != rv2);
            B_LT:    take = ($signed(rv1) <  $signed(rv2));
            B_GE:    take = ($signed(rv1) >= $signed(rv2));
            B_LTU:   take = (rv1 <  rv2);
            B_GEU:   take = (rv1 >= rv2);
            default: take = 1'b0;   // 010/011 are reserved: never taken
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: fetch over req/ack, hold instruction during
// execution, then resolve the next PC (sequential, branch, JAL, JALR).
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [31:0] rv1,
    input  logic [31:0] rv2,
    input  logic [31:0] imm,
    output logic [31:0] pc,
    output logic        branch_taken,
    output logic        misaligned,
    output logic        fetch_timeout
);

    pcs_state_e  state, state_nxt;
    logic [7:0]  wait_cnt;
    logic        take;
    logic        redirect;
    logic        target_bad;
    logic        timeout_hit;
    logic [31:0] target;

    branch_cmp u_branch_cmp (
        .b_func (instr[14:12]),
        .rv1    (rv1),
        .rv2    (rv2),
        .take   (take)
    );

    always_comb begin
        target   = pc + PC_STEP;
        redirect = 1'b0;
        case (instr[6:0])
            OP_BRANCH: begin
                if (take) begin
                    target   = pc + imm;
                    redirect = 1'b1;
                end
            end
            OP_JAL: begin
                target   = pc + imm;
                redirect = 1'b1;
            end
            OP_JALR: begin
                target   = (rv1 + imm) & ~32'h1;
                redirect = 1'b1;
            end
            default: ;
        endcase
    end

    assign target_bad  = |target[1:0];
    // The counter holds the number of ack-less cycles already spent, so the
    // MAX_WAIT-th such cycle is the one that gives up.
    assign timeout_hit = (wait_cnt == 8'(MAX_WAIT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ack)         state_nxt = S_EXEC;
                else if (timeout_hit) state_nxt = S_HALT;
            end
            S_EXEC:   if (exec_done) state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = target_bad ? S_HALT : S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            instr         <= '0;
            wait_cnt      <= '0;
            branch_taken  <= 1'b0;
            misaligned    <= 1'b0;
            fetch_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            branch_taken <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        fetch_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_UPDATE: begin
                    if (target_bad) begin
                        misaligned <= 1'b1;
                    end else begin
                        pc           <= target;
                        branch_taken <= redirect;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_EXEC);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a next-PC reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic [31:0] rv1 = '0, rv2 = '0, imm = '0;
    logic [31:0] pc;
    logic        branch_taken, misaligned, fetch_timeout;

    int vecs = 0;
    int errs = 0;
    logic [31:0] m_pc;
    bit          m_halt;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] JALR = 32'h0000_0067;

    pc_sequencer #(.RESET_PC(32'h0), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .exec_done(exec_done), .rv1(rv1), .rv2(rv2),
        .imm(imm), .pc(pc), .branch_taken(branch_taken), .misaligned(misaligned),
        .fetch_timeout(fetch_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_branch(input logic [2:0] f3);
        return {17'b0, f3, 5'b0, 7'b1100011};
    endfunction

    // Reference: architectural next-PC rule, straight from the ISA semantics.
    function automatic logic [31:0] ref_next(input logic [31:0] ins, p, r1, r2, im,
                                             output bit redir);
        int signed s1, s2;
        bit t;
        s1 = $signed(r1);
        s2 = $signed(r2);
        redir = 0;
        if (ins[6:0] == 7'h63) begin
            case (ins[14:12])
                3'd0: t = (r1 == r2);
                3'd1: t = (r1 != r2);
                3'd4: t = (s1 < s2);
                3'd5: t = (s1 >= s2);
                3'd6: t = (r1 < r2);
                3'd7: t = (r1 >= r2);
                default: t = 0;
            endcase
            redir = t;
            return t ? p + im : p + 4;
        end else if (ins[6:0] == 7'h6F) begin
            redir = 1;
            return p + im;
        end else if (ins[6:0] == 7'h67) begin
            redir = 1;
            return (r1 + im) & 32'hFFFF_FFFE;
        end
        return p + 4;
    endfunction

    task automatic do_reset();
        imem_ack = 0; exec_done = 0;
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        m_pc = 32'h0; m_halt = 0;
    endtask

    // One instruction through FETCH/EXEC/UPDATE with optional ack/done delays.
    task automatic exec_one(input logic [31:0] ins, r1, r2, im, input int ack_dly, done_dly);
        int n;
        bit redir, bad;
        logic [31:0] tgt;
        n = 0;
        while (imem_req !== 1'b1 && n < 5) begin @(posedge clk); #1; n++; end
        vecs++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            errs++;
            $display("FAIL fetch_req: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, m_pc);
        end
        for (int i = 0; i < ack_dly; i++) begin
            @(posedge clk); #1;
            vecs++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || fetch_timeout !== 1'b0) begin
                errs++;
                $display("FAIL fetch_hold: req=%b addr=%h to=%b, required 1 %h 0", imem_req, imem_addr, fetch_timeout, m_pc);
            end
        end
        imem_rdata = ins; imem_ack = 1;
        @(posedge clk); #1;
        imem_ack = 0; imem_rdata = $urandom;
        rv1 = r1; rv2 = r2; imm = im;
        for (int i = 0; i <= done_dly; i++) begin
            vecs++;
            if (instr_valid !== 1'b1 || instr !== ins || imem_req !== 1'b0) begin
                errs++;
                $display("FAIL exec: valid=%b instr=%h req=%b, required 1 %h 0", instr_valid, instr, imem_req, ins);
            end
            if (i == done_dly) exec_done = 1;
            else imem_ack = 1;   // acks outside FETCH must be ignored
            @(posedge clk); #1;
            imem_ack = 0;
        end
        exec_done = 0;
        @(posedge clk); #1;
        rv1 = $urandom; rv2 = $urandom; imm = $urandom;
        tgt = ref_next(ins, m_pc, r1, r2, im, redir);
        bad = (tgt[1:0] != 2'b00);
        if (!bad) m_pc = tgt;
        m_halt = bad;
        vecs++;
        if (pc !== m_pc || branch_taken !== (redir && !bad) || misaligned !== bad) begin
            errs++;
            $display("FAIL update: ins=%h pc=%h bt=%b mis=%b, required pc=%h bt=%b mis=%b",
                     ins, pc, branch_taken, misaligned, m_pc, redir && !bad, bad);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || instr !== 32'h0 || instr_valid !== 1'b0 ||
            branch_taken !== 1'b0 || misaligned !== 1'b0 || fetch_timeout !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: pc=%h req=%b instr=%h v=%b bt=%b mis=%b to=%b, required all 0",
                     pc, imem_req, instr, instr_valid, branch_taken, misaligned, fetch_timeout);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        imem_ack = 1; exec_done = 1; imem_rdata = NOP;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            vecs++;
            if (imem_req !== (k % 3 == 1) ||
                (k % 3 == 1 && imem_addr !== 32'((k / 3) * 4))) begin
                errs++;
                $display("FAIL seq_cycle%0d: req=%b addr=%h, required req=%b addr=%h",
                         k, imem_req, imem_addr, (k % 3 == 1), (k / 3) * 4);
            end
        end
        imem_ack = 0; exec_done = 0;
    endtask

    task automatic test_branches();
        do_reset();
        exec_one(JAL, 0, 0, 32'h100, 0, 0);
        exec_one(mk_branch(3'b000), 10, 10, 32'hFF0, 0, 0);        // BEQ taken -> 0x10F0
        exec_one(JAL, 0, 0, 32'h100 - 32'h10F0, 1, 1);
        exec_one(mk_branch(3'b000), 5, 10, 32'hFF0, 0, 0);         // BEQ not taken -> 0x104
        exec_one(mk_branch(3'b100), 10, 32'hFFFF_FFF1, 32'h40, 2, 0); // BLT not taken
        exec_one(mk_branch(3'b110), 10, 32'hFFFF_FFF1, 32'h40, 0, 2); // BLTU taken
        exec_one(mk_branch(3'b010), 1, 2, 32'h40, 0, 0);           // reserved: never taken
        exec_one(JALR, 32'hFFFF_FFFD, 32'h0, 32'hFFFF_FFFF, 0, 0);  // -> 0xFFFF_FFFC
        exec_one(NOP, 0, 0, 0, 0, 0);                              // wraps to 0
    endtask

    task automatic test_jalr_misaligned();
        do_reset();
        exec_one(JALR, 32'h203, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1; exec_done = 1;
            @(posedge clk); #1;
            vecs++;
            if (imem_req !== 1'b0 || pc !== 32'h0 || misaligned !== 1'b1 || instr_valid !== 1'b0) begin
                errs++;
                $display("FAIL halt_misaligned: req=%b pc=%h mis=%b v=%b, required 0 0 1 0",
                         imem_req, pc, misaligned, instr_valid);
            end
        end
        imem_ack = 0; exec_done = 0;
    endtask

    task automatic test_timeout();
        int fetch_cycles;
        do_reset();
        fetch_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (imem_req === 1'b1) fetch_cycles++;
        end
        vecs++;
        if (fetch_cycles != 4 || fetch_timeout !== 1'b1 || imem_req !== 1'b0 || misaligned !== 1'b0) begin
            errs++;
            $display("FAIL timeout: fetch_cycles=%0d to=%b req=%b mis=%b, required 4 1 0 0",
                     fetch_cycles, fetch_timeout, imem_req, misaligned);
        end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        exec_one(JAL, 0, 0, 32'h40, 0, 0);
        while (imem_req !== 1'b1) begin @(posedge clk); #1; end
        imem_rdata = JAL; imem_ack = 1;
        @(posedge clk); #1;
        imem_ack = 0; exec_done = 1; reset = 0;
        @(posedge clk); #1;
        reset = 1; exec_done = 0;
        vecs++;
        if (pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
            branch_taken !== 1'b0 || misaligned !== 1'b0 || fetch_timeout !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid_exec: pc=%h instr=%h v=%b req=%b bt=%b, required all 0",
                     pc, instr, instr_valid, imem_req, branch_taken);
        end
        @(posedge clk); #1;
        vecs++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errs++;
            $display("FAIL restart_fetch: req=%b addr=%h, required 1 0", imem_req, imem_addr);
        end
        m_pc = 0; m_halt = 0;
    endtask

    task automatic test_random();
        logic [31:0] ins, r1, r2, im;
        int sel;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if (m_halt) do_reset();
            sel = $urandom_range(0, 9);
            im = 32'(($urandom_range(0, 1023) - 512) * 4);
            if ($urandom_range(0, 7) == 0) im = im + 32'($urandom_range(1, 3));
            r1 = $urandom;
            r2 = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
            if (sel <= 4) ins = mk_branch(3'($urandom_range(0, 7)));
            else if (sel == 5) ins = JAL;
            else if (sel == 6) begin
                ins = JALR;
                r1 = {18'b0, 12'($urandom), 2'b00};
                if ($urandom_range(0, 5) == 0) r1 = r1 + 32'($urandom_range(1, 3));
            end else ins = {$urandom} & 32'hFFFF_FF80 | 32'h33;
            exec_one(ins, r1, r2, im, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branches();
        test_jalr_misaligned();
        test_timeout();
        test_reset_mid_exec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
